// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio playback path.
//   WORD_LENGTH          : bits per clip-memory sample word
//   BIT_PERIOD_DEFAULT   : default clock cycles per serial output bit
//   deserializer_state_t : audio_deserializer control states
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int WORD_LENGTH        = 16;
    localparam int BIT_PERIOD_DEFAULT = 50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STALL = 2'd3
    } deserializer_state_t;

endpackage

// File: rtl/audio_deserializer_if.sv
// -----------------------------------------------------------------------------
// audio_deserializer_if
// Word fetch handshake between the deserializer and the clip memory bank.
//   word_req   : one-cycle request for the next sample word (deserializer -> memory)
//   word       : sample word (memory -> deserializer), meaningful with word_valid
//   word_valid : word carries the answer to the outstanding request
// Modports: master = deserializer side, slave = memory side.
// -----------------------------------------------------------------------------
interface audio_deserializer_if #(
    parameter int WORD_LENGTH = audio_pkg::WORD_LENGTH
);
    logic                   word_req;
    logic [WORD_LENGTH-1:0] word;
    logic                   word_valid;

    modport master (output word_req, input word, input word_valid);
    modport slave  (input word_req, output word, output word_valid);
endinterface

// File: rtl/audio_deserializer_bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Free-running modulo-BIT_PERIOD counter with synchronous clear.
//   clock_i, reset_i : clock, synchronous active-high reset
//   clear_i          : hold the counter at 0 (bit slot restarts when released)
//   tick_o           : high in the last cycle of each bit slot
//   pre_tick_o       : high in the cycle before tick_o (BIT_PERIOD >= 2)
// -----------------------------------------------------------------------------
module bit_tick_gen #(
    parameter int BIT_PERIOD = 50
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);
    localparam int CNT_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BIT_PERIOD - 2);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || (count_q == CNT_LAST)) begin
            count_d = '0;
        end
    end

    assign tick_o     = !clear_i && (count_q == CNT_LAST);
    assign pre_tick_o = !clear_i && (count_q == CNT_PRE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/audio_deserializer.sv
// -----------------------------------------------------------------------------
// audio_deserializer
// Fetches sample words from clip memory (one word prefetched) and shifts them
// out MSB-first as a 1-bit audio stream, BIT_PERIOD cycles per bit.
//   clock_i, reset_i   : clock, synchronous active-high reset
//   enable_i           : playback enable (level); low returns to IDLE next cycle
//   mem                : word request / word / valid handshake (master side)
//   audio_o            : serial audio bit
//   audio_sd_o         : amplifier shutdown-not, 1 while playing or stalled
//   done_o             : pulse in the final cycle of each consumed word
//   underrun_o         : sticky, a word ended with nothing ready to follow it
//   underrun_count_o   : saturating underrun event count (only with
//                        DESERIALIZER_UNDERRUN_COUNT_EN defined)
// Optional feature macro: DESERIALIZER_UNDERRUN_COUNT_EN
// -----------------------------------------------------------------------------
module audio_deserializer #(
    parameter int WORD_LENGTH = audio_pkg::WORD_LENGTH,
    parameter int BIT_PERIOD  = audio_pkg::BIT_PERIOD_DEFAULT
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    audio_deserializer_if.master mem,
    output logic                audio_o,
    output logic                audio_sd_o,
    output logic                done_o,
    output logic                underrun_o
`ifdef DESERIALIZER_UNDERRUN_COUNT_EN
    ,
    output logic [7:0]          underrun_count_o
`endif
);
    import audio_pkg::*;

    localparam int IDX_W = $clog2(WORD_LENGTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WORD_LENGTH - 1);

    deserializer_state_t    state_q, state_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d, buf_q, buf_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic buf_vld_q, buf_vld_d, outst_q, outst_d;
    logic req_q, req_d, audio_q, audio_d, sd_q, sd_d;
    logic done_q, done_d, underrun_q, underrun_d;
    logic tick, pre_tick, accept, load;

    // The bit slot counter only runs while shifting; it sits at 0 otherwise,
    // so a freshly loaded word always gets a full first bit.
    bit_tick_gen #(.BIT_PERIOD(BIT_PERIOD)) u_bit_tick_gen (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clear_i    (state_q != ST_SHIFT),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    // Responses without an outstanding request are ignored.
    assign accept = mem.word_valid && outst_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: if (accept) state_d = ST_SHIFT;
                ST_SHIFT: if (tick && (idx_q == '0) && !buf_vld_q && !accept) state_d = ST_STALL;
                ST_STALL: if (accept) state_d = ST_SHIFT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Shift register, prefetch buffer and request bookkeeping.
    always_comb begin
        shift_d    = shift_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        outst_d    = outst_q;
        underrun_d = underrun_q;
        req_d      = 1'b0;
        load       = 1'b0;
        if (!enable_i) begin
            shift_d   = '0;
            idx_d     = '0;
            buf_vld_d = 1'b0;
            outst_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    underrun_d = 1'b0;
                    req_d      = 1'b1;
                    outst_d    = 1'b1;
                end
                ST_FETCH, ST_STALL: begin
                    if (accept) begin
                        shift_d = mem.word;
                        idx_d   = IDX_MSB;
                        outst_d = 1'b0;
                        load    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (accept) begin
                        buf_d     = mem.word;
                        buf_vld_d = 1'b1;
                        outst_d   = 1'b0;
                    end
                    if (tick) begin
                        if (idx_q != '0) begin
                            shift_d = shift_q << 1;
                            idx_d   = idx_q - 1'b1;
                        end else if (buf_vld_q) begin
                            shift_d   = buf_q;
                            idx_d     = IDX_MSB;
                            buf_vld_d = 1'b0;
                            load      = 1'b1;
                        end else if (accept) begin
                            // Word arrived exactly at the boundary: bypass the buffer.
                            shift_d   = mem.word;
                            idx_d     = IDX_MSB;
                            buf_vld_d = 1'b0;
                            load      = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Request issued on the load edge so it is visible in the first
            // cycle of the new word; at most one per word.
            if (load && !buf_vld_d && !outst_d) begin
                req_d   = 1'b1;
                outst_d = 1'b1;
            end
        end
    end

    // Registered outputs derived from the next state. done_o looks one cycle
    // ahead (pre_tick) so the pulse lands in the word's final cycle.
    always_comb begin
        audio_d = (state_d == ST_SHIFT) && shift_d[WORD_LENGTH-1];
        sd_d    = (state_d == ST_SHIFT) || (state_d == ST_STALL);
        done_d  = enable_i && (state_q == ST_SHIFT) && (idx_q == '0) && pre_tick;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shift_q    <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            outst_q    <= 1'b0;
            req_q      <= 1'b0;
            audio_q    <= 1'b0;
            sd_q       <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            outst_q    <= outst_d;
            req_q      <= req_d;
            audio_q    <= audio_d;
            sd_q       <= sd_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign mem.word_req = req_q;
    assign audio_o      = audio_q;
    assign audio_sd_o   = sd_q;
    assign done_o       = done_q;
    assign underrun_o   = underrun_q;

`ifdef DESERIALIZER_UNDERRUN_COUNT_EN
    logic [7:0] underrun_count_q, underrun_count_d;

    always_comb begin
        underrun_count_d = underrun_count_q;
        if ((state_q == ST_IDLE) && (state_d == ST_FETCH)) begin
            underrun_count_d = '0;
        end else if ((state_q == ST_SHIFT) && (state_d == ST_STALL) && (underrun_count_q != 8'hFF)) begin
            underrun_count_d = underrun_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            underrun_count_q <= '0;
        end else begin
            underrun_count_q <= underrun_count_d;
        end
    end

    assign underrun_count_o = underrun_count_q;
`endif
endmodule
